rob_recovery_ctrl: RTL and testbench
====================================

# rob_recovery_ctrl

Sequences branch-mispredict recovery for the reorder buffer. On a mispredict it walks ROB entries from tail-1 back to the mispredicted branch, one entry per cycle. For each squashed entry it issues a Map Table restore (dest_idx ← Told_idx), a Free List return (T_idx) and an ROB invalidate. It stalls dispatch for the duration, then publishes the new tail. It sits between the branch-resolution path, the ROB read port, the Map Table and the Free List.

## Interface
Parameters:
- NUM_ROB, 8: ROB entries; power of two. RW = $clog2(NUM_ROB).
- NUM_PR, 64: physical registers. PW = $clog2(NUM_PR).
- NUM_AR, 32: architectural registers. AW = $clog2(NUM_AR).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- mispredict_valid  in  1  branch resolved mispredicted this cycle.
- mispredict_rob_idx  in  RW  ROB index of that branch.
- rob_head  in  RW  current ROB head.
- rob_tail  in  RW  current ROB tail (next free slot).
- walk_idx  out  RW  ROB entry read this cycle.
- walk_rd_valid  in  1  valid bit of entry walk_idx (combinational read).
- walk_rd_T_idx  in  PW  T of entry walk_idx.
- walk_rd_Told_idx  in  PW  Told of entry walk_idx.
- walk_rd_dest_idx  in  AW  architectural dest of entry walk_idx.
- busy  out  1  recovery in progress; gates dispatch.
- map_restore_en  out  1  Map Table writes map[map_restore_dest_idx] ← map_restore_T_idx.
- map_restore_dest_idx  out  AW  register being restored.
- map_restore_T_idx  out  PW  value to restore (entry Told).
- fl_return_en  out  1  Free List pushes fl_return_idx.
- fl_return_idx  out  PW  entry T.
- rob_squash_en  out  1  ROB clears the valid bit of walk_idx.
- tail_set_en  out  1  one-cycle pulse: ROB tail ← tail_set_idx.
- tail_set_idx  out  RW  mispredict index + 1, mod NUM_ROB.

## Operation
- States: IDLE, WALK, DONE. Registers: state, walk_idx, stop_idx.
- IDLE, mispredict_valid=1: stop_idx ← mispredict_rob_idx; walk_idx ← rob_tail-1 (mod NUM_ROB).
  - If rob_tail-1 == mispredict_rob_idx, go to DONE (nothing younger).
  - Otherwise go to WALK.
- WALK, each cycle, if walk_rd_valid=1:
  - rob_squash_en=1.
  - map_restore_en=1 with dest=walk_rd_dest_idx and T=walk_rd_Told_idx.
  - fl_return_en=1 with idx=walk_rd_T_idx.
  - An invalid entry produces no pulses but still consumes the cycle.
- WALK, advance: if walk_idx-1 == stop_idx go to DONE; otherwise walk_idx ← walk_idx-1. All index arithmetic wraps mod NUM_ROB.
- DONE: tail_set_en=1 and tail_set_idx=stop_idx+1; go to IDLE.
- busy=1 in WALK and DONE, and combinationally in IDLE when mispredict_valid=1.
- Age: age(i) = (i - rob_head) mod NUM_ROB; smaller means older.
- mispredict_valid during WALK:
  - If age(new idx) < age(stop_idx), stop_idx ← new idx; the walk continues toward the older branch.
  - Otherwise the new mispredict is ignored.
- mispredict_valid during DONE: ignored.
- Retirement at head during WALK is allowed and does not alter the walk.
- Full ROB (head == tail): walk starts at tail-1 and wraps normally.
- Restore outputs are combinational from registered state, walk_idx and the walk_rd_* inputs; all other outputs come from registers.

## Timing
- Reset: state=IDLE, walk_idx=0, stop_idx=0. All *_en outputs 0, busy=0, data outputs 0.
- Reset asserted mid-WALK aborts the walk the next edge with no further pulses. The ROB, Map Table and Free List are reset concurrently.
- N younger entries: WALK lasts N cycles and DONE 1 cycle. busy is high from the mispredict cycle through DONE, N+2 cycles.
- Restores go youngest first, so the last restore of an architectural register leaves the oldest Told.
- tail_set_en is sampled by the ROB at the DONE clock edge; dispatch may resume the following cycle.

## Configuration
- ROB_RECOVERY_SKIP_ZERO_EN defined:
  - Entries with walk_rd_dest_idx == NUM_AR-1 (R31 zero register) issue rob_squash_en only.
  - They issue no map_restore_en or fl_return_en, and still consume one walk cycle.
- Undefined: every valid entry issues all three pulses.

## Structure
- Shared package: RECOVERY_STATE_t enum (IDLE/WALK/DONE); a ROB_RECOVERY_OUT_t struct bundling the restore, return and squash fields; NUM_ROB/NUM_PR/NUM_AR via the existing `defines.
- Sub-module rob_age_cmp: combinational modular age compare of two indices against head. Used for retargeting.

## Test plan
- Reset → busy=0, all enables 0, walk_idx=0.
- head=0, tail=5, mispredict idx=1 → restores entries 4,3,2 on consecutive cycles; tail_set_idx=2; busy high 5 cycles.
- mispredict idx=tail-1=3 → no restores; DONE next cycle with tail_set_idx=4; busy 2 cycles.
- Wrap: NUM_ROB=8, head=6, tail=2, mispredict idx=7 → walks 1,0; tail_set_idx=0.
- During WALK (stop_idx=5, head=2), a second mispredict idx=3 → stop_idx retargets to 3 and entries 5 and 4 are also restored. A mispredict at idx=6 instead is ignored.
- Entry with dest_idx=31 under ROB_RECOVERY_SKIP_ZERO_EN → squash only. Without the macro → squash, restore and return.

Source files
------------

// File: rtl/rob_recovery_ctrl_pkg.sv
// rob_recovery_ctrl_pkg: shared types and default sizes for branch-mispredict ROB recovery.
package rob_recovery_ctrl_pkg;
  localparam int DEF_NUM_ROB = 8;
  localparam int DEF_NUM_PR = 64;
  localparam int DEF_NUM_AR = 32;
  localparam int DEF_PW = $clog2(DEF_NUM_PR);
  localparam int DEF_AW = $clog2(DEF_NUM_AR);
  typedef enum logic [1:0] {IDLE, WALK, DONE} RECOVERY_STATE_t;
  typedef struct packed {
    logic map_restore_en;
    logic [DEF_AW-1:0] map_restore_dest_idx;
    logic [DEF_PW-1:0] map_restore_T_idx;
    logic fl_return_en;
    logic [DEF_PW-1:0] fl_return_idx;
    logic rob_squash_en;
  } ROB_RECOVERY_OUT_t;
endpackage

// File: rtl/rob_age_cmp.sv
// rob_age_cmp: true when index a is older than index b, ages measured from the ROB head.
module rob_age_cmp #(
  parameter int RW = 3
) (
  input  logic [RW-1:0] head,
  input  logic [RW-1:0] a,
  input  logic [RW-1:0] b,
  output logic          a_older
);
  logic [RW-1:0] age_a, age_b;
  assign age_a = a - head;
  assign age_b = b - head;
  assign a_older = age_a < age_b;
endmodule

// File: rtl/rob_recovery_ctrl.sv
// rob_recovery_ctrl: walks squashed ROB entries youngest-first after a mispredict, then publishes the new tail.
// Define ROB_RECOVERY_SKIP_ZERO_EN to suppress restore/return for entries writing R31.
module rob_recovery_ctrl
  import rob_recovery_ctrl_pkg::*;
#(
  parameter int NUM_ROB = DEF_NUM_ROB,
  parameter int NUM_PR = DEF_NUM_PR,
  parameter int NUM_AR = DEF_NUM_AR,
  localparam int RW = $clog2(NUM_ROB),
  localparam int PW = $clog2(NUM_PR),
  localparam int AW = $clog2(NUM_AR)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          mispredict_valid,
  input  logic [RW-1:0] mispredict_rob_idx,
  input  logic [RW-1:0] rob_head,
  input  logic [RW-1:0] rob_tail,
  output logic [RW-1:0] walk_idx,
  input  logic          walk_rd_valid,
  input  logic [PW-1:0] walk_rd_T_idx,
  input  logic [PW-1:0] walk_rd_Told_idx,
  input  logic [AW-1:0] walk_rd_dest_idx,
  output logic          busy,
  output logic          map_restore_en,
  output logic [AW-1:0] map_restore_dest_idx,
  output logic [PW-1:0] map_restore_T_idx,
  output logic          fl_return_en,
  output logic [PW-1:0] fl_return_idx,
  output logic          rob_squash_en,
  output logic          tail_set_en,
  output logic [RW-1:0] tail_set_idx
);
  RECOVERY_STATE_t state, state_n;
  logic [RW-1:0] stop_idx, walk_n, stop_n, stop_eff, walk_m1, tail_m1;
  logic new_older, squash, keep;
  ROB_RECOVERY_OUT_t ro;
  rob_age_cmp #(.RW(RW)) u_age (
    .head(rob_head),
    .a(mispredict_rob_idx),
    .b(stop_idx),
    .a_older(new_older)
  );
  assign walk_m1 = walk_idx - RW'(1);
  assign tail_m1 = rob_tail - RW'(1);
  assign stop_eff = (mispredict_valid && new_older) ? mispredict_rob_idx : stop_idx;
`ifdef ROB_RECOVERY_SKIP_ZERO_EN
  assign keep = walk_rd_dest_idx != AW'(NUM_AR - 1);
`else
  assign keep = 1'b1;
`endif
  // Reset gates the pulses so an aborted walk emits nothing in its last cycle.
  assign squash = state == WALK && walk_rd_valid && !reset;
  always_comb begin
    ro = '0;
    ro.rob_squash_en = squash;
    ro.map_restore_en = squash && keep;
    ro.fl_return_en = squash && keep;
    ro.map_restore_dest_idx = ro.map_restore_en ? walk_rd_dest_idx : '0;
    ro.map_restore_T_idx = ro.map_restore_en ? walk_rd_Told_idx : '0;
    ro.fl_return_idx = ro.fl_return_en ? walk_rd_T_idx : '0;
  end
  assign map_restore_en = ro.map_restore_en;
  assign map_restore_dest_idx = ro.map_restore_dest_idx;
  assign map_restore_T_idx = ro.map_restore_T_idx;
  assign fl_return_en = ro.fl_return_en;
  assign fl_return_idx = ro.fl_return_idx;
  assign rob_squash_en = ro.rob_squash_en;
  assign busy = state != IDLE || mispredict_valid;
  assign tail_set_en = state == DONE;
  assign tail_set_idx = state == DONE ? stop_idx + RW'(1) : '0;
  always_comb begin
    state_n = state;
    walk_n = walk_idx;
    stop_n = stop_idx;
    if (state == IDLE && mispredict_valid) begin
      stop_n = mispredict_rob_idx;
      walk_n = tail_m1;
      state_n = tail_m1 == mispredict_rob_idx ? DONE : WALK;
    end else if (state == WALK) begin
      stop_n = stop_eff;
      state_n = walk_m1 == stop_eff ? DONE : WALK;
      walk_n = walk_m1 == stop_eff ? walk_idx : walk_m1;
    end else if (state == DONE) begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      walk_idx <= '0;
      stop_idx <= '0;
    end else begin
      state <= state_n;
      walk_idx <= walk_n;
      stop_idx <= stop_n;
    end
  end
endmodule

// File: tb/tb_rob_recovery_ctrl.sv
// tb_rob_recovery_ctrl: directed checks of mispredict walk, retargeting, wrap, zero-register handling and reset abort.
module tb_rob_recovery_ctrl;
  logic clock = 0;
  logic reset;
  logic mispredict_valid;
  logic [2:0] mispredict_rob_idx, rob_head, rob_tail, walk_idx, tail_set_idx;
  logic walk_rd_valid, busy, map_restore_en, fl_return_en, rob_squash_en, tail_set_en;
  logic [5:0] walk_rd_T_idx, walk_rd_Told_idx, map_restore_T_idx, fl_return_idx;
  logic [4:0] walk_rd_dest_idx, map_restore_dest_idx;
  logic rob_v [8];
  logic [5:0] rob_t [8];
  logic [5:0] rob_told [8];
  logic [4:0] rob_d [8];
  int n_checks = 0;
  int n_fail = 0;
  always #5 clock = ~clock;
  assign walk_rd_valid = rob_v[walk_idx];
  assign walk_rd_T_idx = rob_t[walk_idx];
  assign walk_rd_Told_idx = rob_told[walk_idx];
  assign walk_rd_dest_idx = rob_d[walk_idx];
  rob_recovery_ctrl dut (
    .clock(clock), .reset(reset),
    .mispredict_valid(mispredict_valid), .mispredict_rob_idx(mispredict_rob_idx),
    .rob_head(rob_head), .rob_tail(rob_tail), .walk_idx(walk_idx),
    .walk_rd_valid(walk_rd_valid), .walk_rd_T_idx(walk_rd_T_idx),
    .walk_rd_Told_idx(walk_rd_Told_idx), .walk_rd_dest_idx(walk_rd_dest_idx),
    .busy(busy), .map_restore_en(map_restore_en), .map_restore_dest_idx(map_restore_dest_idx),
    .map_restore_T_idx(map_restore_T_idx), .fl_return_en(fl_return_en),
    .fl_return_idx(fl_return_idx), .rob_squash_en(rob_squash_en),
    .tail_set_en(tail_set_en), .tail_set_idx(tail_set_idx)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic next;
    @(posedge clock);
    #1;
  endtask
  task automatic settle;
    #2;
  endtask
  // Checks one squash cycle against the bench's ROB contents for entry i.
  task automatic chk_squash(input string tag, input int i, input logic restore);
    chk({tag, "_walk"}, 32'(walk_idx), 32'(i));
    chk({tag, "_busy"}, 32'(busy), 1);
    chk({tag, "_squash"}, 32'(rob_squash_en), 1);
    chk({tag, "_map_en"}, 32'(map_restore_en), 32'(restore));
    chk({tag, "_fl_en"}, 32'(fl_return_en), 32'(restore));
    if (restore) begin
      chk({tag, "_dest"}, 32'(map_restore_dest_idx), 32'(rob_d[i]));
      chk({tag, "_told"}, 32'(map_restore_T_idx), 32'(rob_told[i]));
      chk({tag, "_t"}, 32'(fl_return_idx), 32'(rob_t[i]));
    end
    chk({tag, "_tail_en"}, 32'(tail_set_en), 0);
  endtask
  task automatic chk_done(input string tag, input int idx);
    chk({tag, "_busy"}, 32'(busy), 1);
    chk({tag, "_squash"}, 32'(rob_squash_en), 0);
    chk({tag, "_tail_en"}, 32'(tail_set_en), 1);
    chk({tag, "_tail_idx"}, 32'(tail_set_idx), 32'(idx));
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_tail_en"}, 32'(tail_set_en), 0);
    chk({tag, "_squash"}, 32'(rob_squash_en), 0);
  endtask
  task automatic start(input int head, input int tail, input int idx);
    next;
    rob_head = 3'(head);
    rob_tail = 3'(tail);
    mispredict_valid = 1;
    mispredict_rob_idx = 3'(idx);
    settle;
    chk("start_busy", 32'(busy), 1);
    chk("start_squash", 32'(rob_squash_en), 0);
    next;
    mispredict_valid = 0;
    settle;
  endtask
  initial begin
    for (int i = 0; i < 8; i++) begin
      rob_v[i] = 1;
      rob_t[i] = 6'(16 + i);
      rob_told[i] = 6'(40 + i);
      rob_d[i] = 5'(i + 3);
    end
    reset = 1;
    mispredict_valid = 0;
    mispredict_rob_idx = 0;
    rob_head = 0;
    rob_tail = 0;
    next;
    next;
    settle;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_walk", 32'(walk_idx), 0);
    chk("rst_map_en", 32'(map_restore_en), 0);
    chk("rst_fl_en", 32'(fl_return_en), 0);
    chk("rst_squash", 32'(rob_squash_en), 0);
    chk("rst_tail_en", 32'(tail_set_en), 0);
    chk("rst_tail_idx", 32'(tail_set_idx), 0);
    reset = 0;
    // head=0 tail=5 branch 1: squash 4,3,2 then tail 2
    start(0, 5, 1);
    chk_squash("b4", 4, 1);
    next; settle; chk_squash("b3", 3, 1);
    next; settle; chk_squash("b2", 2, 1);
    next; settle; chk_done("bdone", 2);
    next; settle; chk_idle("bidle");
    // nothing younger than the branch
    start(0, 4, 3);
    chk_done("edone", 4);
    next; settle; chk_idle("eidle");
    // wrap: head=6 tail=2 branch 7 -> walk 1,0, tail 0
    start(6, 2, 7);
    chk_squash("w1", 1, 1);
    next; settle; chk_squash("w0", 0, 1);
    next; settle; chk_done("wdone", 0);
    next; settle; chk_idle("widle");
    // retarget to older branch 3; entry 6 invalid still consumes a cycle
    rob_v[6] = 0;
    start(2, 0, 5);
    chk_squash("r7", 7, 1);
    next;
    mispredict_valid = 1;
    mispredict_rob_idx = 3;
    settle;
    chk("r6_walk", 32'(walk_idx), 6);
    chk("r6_squash", 32'(rob_squash_en), 0);
    chk("r6_map_en", 32'(map_restore_en), 0);
    chk("r6_fl_en", 32'(fl_return_en), 0);
    next;
    mispredict_valid = 0;
    settle;
    chk_squash("r5", 5, 1);
    next; settle; chk_squash("r4", 4, 1);
    next; settle; chk_done("rdone", 4);
    next; settle; chk_idle("ridle");
    rob_v[6] = 1;
    // younger mispredict during walk is ignored
    start(2, 0, 5);
    chk_squash("i7", 7, 1);
    next;
    mispredict_valid = 1;
    mispredict_rob_idx = 6;
    settle;
    chk_squash("i6", 6, 1);
    next;
    mispredict_valid = 0;
    settle;
    chk_done("idone", 6);
    next; settle; chk_idle("iidle");
    // full ROB, youngest entry writes R31
    rob_d[7] = 31;
    start(0, 0, 6);
`ifdef ROB_RECOVERY_SKIP_ZERO_EN
    chk_squash("z7", 7, 0);
`else
    chk_squash("z7", 7, 1);
`endif
    next; settle; chk_done("zdone", 7);
    next; settle; chk_idle("zidle");
    // reset mid-walk aborts with no pulses
    start(0, 5, 1);
    chk_squash("a4", 4, 1);
    reset = 1;
    settle;
    chk("a_rst_squash", 32'(rob_squash_en), 0);
    chk("a_rst_map_en", 32'(map_restore_en), 0);
    next;
    settle;
    chk("a_busy", 32'(busy), 0);
    chk("a_walk", 32'(walk_idx), 0);
    chk("a_squash", 32'(rob_squash_en), 0);
    chk("a_tail_en", 32'(tail_set_en), 0);
    reset = 0;
    next; settle;
    chk_idle("a_idle");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
